// File: rtl/word_cell.sv
// One memory-array row: WIDTH identical bitcells sharing a row select and an op line.
// A selected write loads in_bus, a selected read drives the word out, and otherwise out_bus is zero.

module bitcell (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic re,
  input  logic d,
  output logic q,
  output logic rd
);
  always_ff @(posedge clk) begin
    if (rst)     q <= 1'b0;
    else if (we) q <= d;
  end

  assign rd = q & re;
endmodule

module word_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op,
  input  logic             sel_x,
  input  logic [WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0] out_bus,
  output logic [WIDTH-1:0] stored_value
);
  logic we, re;

  // The row decodes op and select once. Every cell shares the same enables.
  assign we = sel_x & op;
  assign re = sel_x & ~op;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    bitcell u_cell (
      .clk (clk),
      .rst (rst),
      .we  (we),
      .re  (re),
      .d   (in_bus[i]),
      .q   (stored_value[i]),
      .rd  (out_bus[i])
    );
  end
endmodule

// File: tb/tb_word_cell.sv
// Self-checking bench for word_cell: a directed vector table, a zero-latency read sequence and a random phase.
// Expected stored values pass through a scoreboard queue.

module tb_word_cell;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, op, sel_x;
  logic [W-1:0] in_bus, out_bus, stored_value;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] model;

  typedef struct {
    logic         rst;
    logic         op;
    logic         sel_x;
    logic [W-1:0] din;
    logic [W-1:0] exp_out;    // out_bus before the edge (combinational)
    logic [W-1:0] exp_store;  // stored_value after the edge
  } vec_t;

  vec_t vecs[14];

  word_cell #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .sel_x        (sel_x),
    .in_bus       (in_bus),
    .out_bus      (out_bus),
    .stored_value (stored_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle: check out_bus before the edge and the scoreboarded stored value after it.
  task automatic step(input string name, input logic r, input logic o, input logic s,
                      input logic [W-1:0] d, input logic [W-1:0] exp_out,
                      input logic [W-1:0] exp_store);
    logic [W-1:0] e;
    @(negedge clk);
    rst = r; op = o; sel_x = s; in_bus = d;
    sb_q.push_back(exp_store);
    #1 chk({name, " out_bus"}, out_bus, exp_out);
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", name);
    end else begin
      e = sb_q.pop_front();
      if (stored_value !== e) begin
        errors++;
        $display("FAIL %s stored_value: got %b expected %b", name, stored_value, e);
      end
    end
  endtask

  initial begin
    rst = 1'b0; op = 1'b0; sel_x = 1'b0; in_bus = '0;

    //            rst   op    sel   din     exp_out exp_store
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00}; // reset
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 8'h00}; // unselected write is ignored
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h55, 8'h00, 8'h00}; // read of reset contents, no write
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 8'h55}; // write, out_bus stays 0
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h55, 8'h55}; // read back
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h55}; // deselected hold
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'hCC, 8'h00, 8'hCC}; // overwrite
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hCC, 8'hCC}; // read new data next cycle
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'hF0, 8'h00, 8'h00}; // reset beats write
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00}; // read after reset
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF}; // back-to-back writes
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h00, 8'h01}; // last write wins
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'hAA, 8'h01, 8'h01}; // read ignores in_bus
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'hAA, 8'h00, 8'h01}; // unselected write, out_bus 0

    for (int i = 0; i < 14; i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].sel_x,
           vecs[i].din, vecs[i].exp_out, vecs[i].exp_store);

    // The read path is combinational: toggle the select without clocking.
    @(negedge clk);
    rst = 1'b0; op = 1'b0; sel_x = 1'b1; in_bus = 8'h3C;
    #1 chk("comb read sel=1", out_bus, 8'h01);
    sel_x = 1'b0;
    #1 chk("comb read sel=0", out_bus, 8'h00);
    sel_x = 1'b1; op = 1'b1;
    #1 chk("comb write op=1", out_bus, 8'h00);
    chk("comb stored", stored_value, 8'h01);
    op = 1'b0;
    @(posedge clk);

    // Random phase using an independent behavioural model.
    model = 8'h01;
    for (int i = 0; i < 300; i++) begin
      logic r, o, s;
      logic [W-1:0] d, eo;
      r  = ($urandom_range(0, 15) == 0);
      o  = $urandom_range(0, 1);
      s  = $urandom_range(0, 1);
      d  = W'($urandom);
      eo = (s && !o) ? model : '0;
      if (r)           model = '0;
      else if (s && o) model = d;
      step($sformatf("rand%0d", i), r, o, s, d, eo, model);
    end

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
